// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one CPU load/store at a time, stalls the
// pipeline for a fixed latency, then completes with a one-cycle ack and error flag.
module dmem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] Writedata_i,
    output logic [31:0] Readdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg;
    logic [7:0]      cnt_reg;
    logic [AW-1:0]   idx_reg;
    logic [31:0]     wdata_reg;
    logic            rd_reg;
    logic            wr_reg;
    logic            acc_err_reg;
    logic [31:0]     rdata_reg;
    logic            ack_reg;
    logic            err_reg;
    logic [31:0]     mem_reg [DEPTH_WORDS];

    logic            request;
    logic            range_err;
    logic            req_err;
    logic            resp_next;

    assign request = MemRead_i | MemWrite_i;

    // Any address bit above the word-index field means the access is beyond the array.
    generate
        if (AW + 2 < 32) begin : g_range
            assign range_err = |addr_i[31:AW+2];
        end else begin : g_no_range
            assign range_err = 1'b0;
        end
    endgenerate

    assign req_err   = (addr_i[1:0] != 2'b00) | range_err | (MemRead_i & MemWrite_i);
    assign resp_next = (state_reg == BUSY) && (cnt_reg == 8'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 1'b0;
                    err_reg <= 1'b0;
                    if (request) begin
                        idx_reg     <= addr_i[AW+1:2];
                        wdata_reg   <= Writedata_i;
                        rd_reg      <= MemRead_i;
                        wr_reg      <= MemWrite_i;
                        acc_err_reg <= req_err;
                        cnt_reg     <= CNT_INIT;
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 8'd0) begin
                        ack_reg   <= 1'b1;
                        err_reg   <= acc_err_reg;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                RESP: begin
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Read port: registered, loaded only on the edge into RESP so the value holds otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_reg <= 32'h0;
        end else if (resp_next && rd_reg) begin
            rdata_reg <= acc_err_reg ? 32'h0 : mem_reg[idx_reg];
        end
    end

    // Write commits only when leaving RESP, so a reset mid-access never touches the array.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_reg == RESP) && wr_reg && !acc_err_reg) begin
            mem_reg[idx_reg] <= wdata_reg;
        end
    end

    assign stall_o    = ((state_reg == IDLE) && request) || (state_reg == BUSY);
    assign Readdata_o = rdata_reg;
    assign ack_o      = ack_reg;
    assign err_o      = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=4 instance for the main scenarios and
// one LATENCY=2 instance for the minimum-latency case.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd0, wr0, rd2, wr2;
    logic [31:0] a0, d0, a2, d2;
    logic [31:0] q0, q2;
    logic        ack0, stall0, err0, ack2, stall2, err2;

    dmem_responder #(.LATENCY(4), .DEPTH_WORDS(256)) u0 (
        .clk_i(clk), .rst_i(rst), .MemRead_i(rd0), .MemWrite_i(wr0),
        .addr_i(a0), .Writedata_i(d0), .Readdata_o(q0),
        .ack_o(ack0), .stall_o(stall0), .err_o(err0)
    );

    dmem_responder #(.LATENCY(2), .DEPTH_WORDS(256)) u2 (
        .clk_i(clk), .rst_i(rst), .MemRead_i(rd2), .MemWrite_i(wr2),
        .addr_i(a2), .Writedata_i(d2), .Readdata_o(q2),
        .ack_o(ack2), .stall_o(stall2), .err_o(err2)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int sel    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    logic        ack_s, stall_s, err_s;
    logic [31:0] q_s;
    always_comb begin
        ack_s   = (sel != 0) ? ack2   : ack0;
        stall_s = (sel != 0) ? stall2 : stall0;
        err_s   = (sel != 0) ? err2   : err0;
        q_s     = (sel != 0) ? q2     : q0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (sel != 0) begin
            rd2 = rd; wr2 = wr; a2 = a; d2 = d;
        end else begin
            rd0 = rd; wr0 = wr; a0 = a; d0 = d;
        end
    endtask

    // Issues a request in the current (IDLE) cycle, scrambles addr/data mid-access,
    // and returns in the ack cycle.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic chk_q, input logic [31:0] exp_q,
                          input logic keep, output int t_acc, output int t_ack);
        int  lat;
        bit  got;
        lat = (sel != 0) ? 2 : 4;
        drive(rd, wr, a, d);
        #2;
        t_acc = cycle;
        check({tag, "_stall_T"}, 32'(stall_s), 32'd1);
        got = 1'b0;
        for (int n = 1; n <= lat + 3 && !got; n++) begin
            tick();
            if (n == 2) drive(rd, wr, ~a, ~d);
            #2;
            if (ack_s) got = 1'b1;
            else if (n < lat) check({tag, "_stall_busy"}, 32'(stall_s), 32'd1);
        end
        t_ack = cycle;
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(t_ack - t_acc), 32'(lat));
        check({tag, "_err"}, 32'(err_s), 32'(exp_err));
        check({tag, "_stall_resp"}, 32'(stall_s), 32'd0);
        if (chk_q) check({tag, "_rdata"}, q_s, exp_q);
        if (!keep) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ta, tk, ta1, tk1;
        rst = 1'b1;
        rd0 = 0; wr0 = 0; a0 = 0; d0 = 0;
        rd2 = 0; wr2 = 0; a2 = 0; d2 = 0;

        // Reset state
        tick(); tick();
        #2;
        check("rst_rdata", q0, 32'h0);
        check("rst_ack", 32'(ack0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_stall_idle", 32'(stall0), 32'd0);
        rd0 = 1'b1;
        #1;
        check("rst_stall_req", 32'(stall0), 32'd1);
        rd0 = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Basic write then read
        access("wr10", 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0, ta, tk);
        tick(); #2;
        check("wr10_ack_pulse", 32'(ack0), 32'd0);
        access("rd10", 1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0, ta, tk);
        tick();

        // Back-to-back: request held past ack becomes the next access
        access("b2b_wr", 0, 1, 32'h0, 32'h1, 0, 0, 32'h0, 1, ta1, tk1);
        drive(1, 0, 32'h0, 32'h0);
        tick();
        access("b2b_rd", 1, 0, 32'h0, 32'h0, 0, 1, 32'h1, 0, ta, tk);
        check("b2b_total", 32'(tk - ta1), 32'd9);
        tick();

        // Error cases
        access("rd_mis", 1, 0, 32'h6, 32'h0, 1, 1, 32'h0, 0, ta, tk);
        tick();
        access("wr_oor", 0, 1, 32'h400, 32'hFFFFFFFF, 1, 0, 32'h0, 0, ta, tk);
        tick();
        access("rd0_a", 1, 0, 32'h0, 32'h0, 0, 1, 32'h1, 0, ta, tk);
        tick();
        access("wr8_hold", 0, 1, 32'h8, 32'h55, 0, 1, 32'h1, 0, ta, tk);
        tick();
        access("both", 1, 1, 32'h0, 32'h77, 1, 0, 32'h0, 0, ta, tk);
        tick();
        access("rd0_b", 1, 0, 32'h0, 32'h0, 0, 1, 32'h1, 0, ta, tk);
        tick();

        // Reset in BUSY aborts the write
        access("wr20", 0, 1, 32'h20, 32'h12345678, 0, 0, 32'h0, 0, ta, tk);
        tick();
        drive(0, 1, 32'h20, 32'hA5A5A5A5);
        tick();
        tick();
        rst = 1'b1;
        drive(0, 0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        #2;
        check("abort_ack", 32'(ack0), 32'd0);
        check("abort_stall", 32'(stall0), 32'd0);
        check("abort_rdata", q0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(); #2;
            check("abort_no_ack", 32'(ack0), 32'd0);
        end
        access("rd20", 1, 0, 32'h20, 32'h0, 0, 1, 32'h12345678, 0, ta, tk);
        tick();

        // Minimum latency build
        sel = 1;
        access("l2_wr", 0, 1, 32'h4, 32'hCAFEF00D, 0, 0, 32'h0, 0, ta, tk);
        tick();
        access("l2_rd", 1, 0, 32'h4, 32'h0, 0, 1, 32'hCAFEF00D, 0, ta, tk);
        tick(); #2;
        check("l2_stall_after", 32'(stall2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to ack_o; legal range 2..255.
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored; power of two.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 MemRead_i  input  1  read request from CPU; level, held until ack_o.
REQ-006 MemWrite_i  input  1  write request from CPU; level, held until ack_o.
REQ-007 addr_i  input  32  byte address of the access.
REQ-008 Writedata_i  input  32  store data.
REQ-009 Readdata_o  output  32  load data; registered.
REQ-010 ack_o  output  1  one-cycle completion pulse.
REQ-011 stall_o  output  1  freeze request to CPU pipeline/PC while an access is outstanding.
REQ-012 err_o  output  1  access-error flag; valid only in the ack_o cycle.

Function
REQ-013 The block SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 IDLE -> BUSY SHALL occur when (MemRead_i | MemWrite_i) is 1; addr_i, Writedata_i and request type latched in that cycle.
REQ-015 BUSY SHALL load an 8-bit counter with LATENCY-2 on entry; decrement each cycle; BUSY -> RESP when counter is 0.
REQ-016 RESP SHALL last exactly one cycle with ack_o=1, then -> IDLE unconditionally.
REQ-017 Latency: request first seen in IDLE at cycle T -> ack_o high at cycle T+LATENCY.
REQ-018 stall_o SHALL be combinational: 1 when (IDLE and a request is present) or state is BUSY; 0 in RESP and in IDLE without request.
REQ-019 Inputs changing during BUSY SHALL be ignored; latched values only are used.
REQ-020 A request still asserted in the IDLE cycle after RESP SHALL be accepted as a new access (CPU deasserts on ack).
REQ-021 Word index = latched addr[log2(DEPTH_WORDS)+1:2].
REQ-022 Error SHALL be flagged when latched addr[1:0] != 0, when addr >= 4*DEPTH_WORDS, or when MemRead_i and MemWrite_i were both 1 at acceptance.
REQ-023 Write: memory word updated at the RESP clock edge only, and only if no error.
REQ-024 Read: Readdata_o loaded with addressed word at the edge entering RESP; on error loaded with 32'h0.
REQ-025 Readdata_o SHALL hold its value outside read acks; writes do not modify it.
REQ-026 err_o SHALL be 1 only in the RESP cycle of an errored access, else 0.
REQ-027 Read of a word written by the immediately preceding access SHALL return the new data.

Reset
REQ-028 rst_i=1 at a clock edge SHALL force state IDLE, counter 0, Readdata_o=0, ack_o=0, err_o=0; stall_o follows REQ-018.
REQ-029 Reset during BUSY SHALL abort the access: no memory write, no ack_o.
REQ-030 Memory array contents SHALL NOT be cleared by reset.
REQ-031 Reset has priority over all other events in the same cycle.

Verification
REQ-032 Write 32'hDEADBEEF to addr 32'h10 at cycle T -> stall_o=1 cycles T..T+3, ack_o=1 at T+4, err_o=0; subsequent read of 32'h10 -> Readdata_o=32'hDEADBEEF with ack 4 cycles after acceptance.
REQ-033 Back-to-back: write 32'h1 to 32'h0, request held one cycle past ack as read of 32'h0 -> second ack at T+9, Readdata_o=32'h1.
REQ-034 Read addr 32'h6 (misaligned) -> ack_o=1, err_o=1, Readdata_o=0; write to 32'h400 with DEPTH_WORDS=256 -> err_o=1, word 0 unchanged.
REQ-035 MemRead_i and MemWrite_i both 1 -> err_o=1 at ack, no memory change.
REQ-036 Write 32'hA5A5A5A5 to 32'h20, rst_i pulsed in BUSY cycle 2 -> no ack_o, state IDLE, read of 32'h20 returns prior value.
REQ-037 LATENCY=2 build: read accepted at T -> ack_o at T+2, stall_o high only at T and T+1.
